harris_run_ctrl: RTL and testbench
==================================

Name: harris_run_ctrl

Overview:
Run sequencer for the harris_hir kernel in simulation and FPGA bring-up.
- Launches one kernel invocation by pulsing the kernel start strobe `t`.
- Monitors the kernel's harris output write port (p1 addr/wr_en) and counts output writes.
- Declares completion after NUM_OUT writes, or on timeout.
- Exposes run statistics (cycles, first-write latency, write count) to the host or bench.

Parameters:
ADDR_WIDTH, 10, width of the harris output write address
NUM_OUT, 1024, output writes that constitute a complete run (1..2^ADDR_WIDTH)
TIMEOUT, 65535, cycle limit for a run, measured from the launch cycle
CNT_WIDTH, 32, width of the cycle and latency counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  run request; sampled only in IDLE
busy  out  1  high in LAUNCH and RUN
t  out  1  kernel start pulse, one cycle wide; drives harris_hir .t
kernel_wr_en  in  1  tap of harris_p1_wr_en
kernel_wr_addr  in  ADDR_WIDTH  tap of harris_p1_addr_data
done  out  1  one-cycle pulse at end of run
timeout  out  1  last run ended by timeout; held until next launch
stray_wr  out  1  sticky; a write was seen outside LAUNCH/RUN
wr_count  out  ADDR_WIDTH+1  writes seen in the current/last run
cycle_count  out  CNT_WIDTH  cycles since launch; frozen at DONE
first_wr_lat  out  CNT_WIDTH  cycle_count value at the first write
order_err  out  1  see Optional Feature
order_err_addr  out  ADDR_WIDTH  see Optional Feature

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs and counters are 0. `t` drops immediately, mid-pulse included. rst is released synchronously into IDLE.
- States: IDLE -> LAUNCH -> RUN -> DONE -> IDLE.
- IDLE:
  - If start=1, go to LAUNCH next cycle.
  - Status outputs hold the previous run's values.
  - A write here sets stray_wr.
- LAUNCH (exactly 1 cycle):
  - t=1, busy=1.
  - cycle_count, wr_count, first_wr_lat, timeout, stray_wr, order_err and order_err_addr are cleared.
  - cycle_count=0 during this cycle.
  - A kernel_wr_en here is counted as a normal write.
  - Next state is RUN.
- RUN:
  - busy=1, t=0.
  - cycle_count increments by 1 each cycle and saturates at all-ones.
  - Each kernel_wr_en increments wr_count.
  - On the first write of the run, latch first_wr_lat = current cycle_count (value before increment). A first write in LAUNCH latches 0.
  - Completion: the cycle whose write makes wr_count == NUM_OUT goes to DONE next cycle, with timeout=0.
  - Timeout: if cycle_count == TIMEOUT and completion is not happening that cycle, go to DONE with timeout=1.
  - Completion and timeout in the same cycle: completion wins, timeout=0.
- DONE (exactly 1 cycle):
  - done=1, busy=0.
  - cycle_count frozen at its RUN exit value.
  - Next state is IDLE. start is ignored in DONE.
- start while busy is ignored; no queuing.
- Writes after completion (in DONE or IDLE) set stray_wr and do not change wr_count.
- wr_count never exceeds NUM_OUT within a run.
- first_wr_lat stays 0 if no write occurred.
- All outputs are registered; done, t and busy come straight from state decode.

Optional Feature:
Macro HARRIS_CTRL_ORDER_CHECK_EN.
- Defined: an expected-address register resets to 0 at LAUNCH and increments on each counted write.
  - A counted write with kernel_wr_addr != expected sets sticky order_err and latches order_err_addr = kernel_wr_addr.
  - Only the first mismatch of a run is latched. Later mismatches do not overwrite it.
  - The expected-address register follows the count, not the received address.
  - order_err does not stop the run.
- Not defined: order_err and order_err_addr are tied to 0 and no checker logic is present.

Test Plan:
- Nominal (NUM_OUT=16, TIMEOUT=100):
  - Stimulus: start pulse in IDLE; kernel model writes addr 0..15, one per cycle, starting 20 cycles after t.
  - Required: t high exactly 1 cycle; first_wr_lat=20; done pulses the cycle after the 16th write; wr_count=16; timeout=0; busy low from DONE.
- Timeout (NUM_OUT=16, TIMEOUT=100):
  - Stimulus: kernel writes only 5 times.
  - Required: done at cycle_count=100 then DONE; timeout=1; wr_count=5; cycle_count holds 100 in IDLE.
- Simultaneous completion and timeout:
  - Stimulus: 16th write lands on the cycle with cycle_count==TIMEOUT.
  - Required: done, timeout=0, wr_count=16.
- Stray write and start while busy:
  - Stimulus: write in IDLE; start asserted again during RUN.
  - Required: stray_wr=1 until the next LAUNCH, which clears it; no second t pulse during RUN; exactly one done.
- Reset mid-run:
  - Stimulus: rst low for 3 cycles during RUN, including once during the t pulse.
  - Required: t, busy, done, counters 0 immediately; IDLE after release; the next start launches cleanly.
- Order check (macro defined):
  - Stimulus: writes addr 0,1,2,7,4,9.
  - Required: order_err=1, order_err_addr=7, wr_count=6.
  - With the macro undefined, order_err stays 0.

Source files
------------

// File: rtl/harris_run_ctrl.sv
// Run sequencer for the harris_hir kernel: launches one invocation, counts output writes, reports stats.
// Optional output-address order checker enabled by defining HARRIS_CTRL_ORDER_CHECK_EN.
module harris_run_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_OUT    = 1024,
  parameter int TIMEOUT    = 65535,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  t,
  input  logic                  kernel_wr_en,
  input  logic [ADDR_WIDTH-1:0] kernel_wr_addr,
  output logic                  done,
  output logic                  timeout,
  output logic                  stray_wr,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [CNT_WIDTH-1:0]  first_wr_lat,
  output logic                  order_err,
  output logic [ADDR_WIDTH-1:0] order_err_addr
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [ADDR_WIDTH:0]  NUM_OUT_W = (ADDR_WIDTH+1)'(NUM_OUT);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_W = CNT_WIDTH'(TIMEOUT);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       active;
  logic       launching;
  logic       wr_counted;
  logic       complete;
  logic       hit_timeout;

  assign active     = (state == S_LAUNCH) || (state == S_RUN);
  assign launching  = (state == S_IDLE) && start;
  assign wr_counted = kernel_wr_en && active && (wr_count != NUM_OUT_W);

  // Also catches a run already full on RUN entry (NUM_OUT=1 written during LAUNCH).
  assign complete = (state == S_RUN) &&
                    ((wr_counted && ((wr_count + (ADDR_WIDTH+1)'(1)) == NUM_OUT_W)) ||
                     (wr_count == NUM_OUT_W));
  assign hit_timeout = (state == S_RUN) && (cycle_count == TIMEOUT_W) && !complete;

  assign t    = (state == S_LAUNCH);
  assign busy = active;
  assign done = (state == S_DONE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_RUN;
      S_RUN:    if (complete || hit_timeout) state_nx = S_DONE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Counters are cleared on the IDLE->LAUNCH edge so they read 0 throughout LAUNCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count     <= '0;
      cycle_count  <= '0;
      first_wr_lat <= '0;
      timeout      <= 1'b0;
      stray_wr     <= 1'b0;
    end else if (launching) begin
      wr_count     <= '0;
      cycle_count  <= '0;
      first_wr_lat <= '0;
      timeout      <= 1'b0;
      stray_wr     <= 1'b0;
    end else begin
      if (kernel_wr_en && !active) stray_wr <= 1'b1;
      if (wr_counted) begin
        wr_count <= wr_count + (ADDR_WIDTH+1)'(1);
        if (wr_count == '0) first_wr_lat <= cycle_count;
      end
      if ((state == S_LAUNCH) || ((state == S_RUN) && (state_nx == S_RUN))) begin
        if (cycle_count != '1) cycle_count <= cycle_count + CNT_WIDTH'(1);
      end
      if (hit_timeout) timeout <= 1'b1;
    end
  end

`ifdef HARRIS_CTRL_ORDER_CHECK_EN
  logic [ADDR_WIDTH-1:0] exp_addr;

  // Expected address tracks the count of accepted writes, not the received address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_addr       <= '0;
      order_err      <= 1'b0;
      order_err_addr <= '0;
    end else if (launching) begin
      exp_addr       <= '0;
      order_err      <= 1'b0;
      order_err_addr <= '0;
    end else if (wr_counted) begin
      exp_addr <= exp_addr + ADDR_WIDTH'(1);
      if ((kernel_wr_addr != exp_addr) && !order_err) begin
        order_err      <= 1'b1;
        order_err_addr <= kernel_wr_addr;
      end
    end
  end
`else
  logic unused_addr;
  assign unused_addr    = ^kernel_wr_addr;
  assign order_err      = 1'b0;
  assign order_err_addr = '0;
`endif

endmodule

// File: tb/tb_harris_run_ctrl.sv
// Directed bench for harris_run_ctrl: table of run scenarios plus hand-written reset/stray sequences.
module tb_harris_run_ctrl;

  localparam int ADDR_WIDTH = 10;
  localparam int NUM_OUT    = 16;
  localparam int TIMEOUT    = 100;
  localparam int CNT_WIDTH  = 32;

`ifdef HARRIS_CTRL_ORDER_CHECK_EN
  localparam int ORD_ERR  = 1;
  localparam int ORD_ADDR = 7;
`else
  localparam int ORD_ERR  = 0;
  localparam int ORD_ADDR = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  busy;
  logic                  t;
  logic                  kernel_wr_en;
  logic [ADDR_WIDTH-1:0] kernel_wr_addr;
  logic                  done;
  logic                  timeout;
  logic                  stray_wr;
  logic [ADDR_WIDTH:0]   wr_count;
  logic [CNT_WIDTH-1:0]  cycle_count;
  logic [CNT_WIDTH-1:0]  first_wr_lat;
  logic                  order_err;
  logic [ADDR_WIDTH-1:0] order_err_addr;

  int total_checks  = 0;
  int passed_checks = 0;

  harris_run_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_OUT(NUM_OUT),
    .TIMEOUT(TIMEOUT),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .t(t),
    .kernel_wr_en(kernel_wr_en),
    .kernel_wr_addr(kernel_wr_addr),
    .done(done),
    .timeout(timeout),
    .stray_wr(stray_wr),
    .wr_count(wr_count),
    .cycle_count(cycle_count),
    .first_wr_lat(first_wr_lat),
    .order_err(order_err),
    .order_err_addr(order_err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    wr_delay;
    int    wr_num;
    int    addr_mode;
    int    exp_done_at;
    int    exp_cycle;
    int    exp_wr_count;
    int    exp_first_lat;
    int    exp_timeout;
    int    exp_stray;
    int    exp_order_err;
    int    exp_order_addr;
  } vec_t;

  vec_t vecs[7];
  int   ord_addr[6] = '{0, 1, 2, 7, 4, 9};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total_checks++;
    if (actual == expected) passed_checks++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Launches one run, drives the write pattern relative to the LAUNCH cycle, and checks DONE/IDLE state.
  task automatic applyStimulus(input vec_t v);
    int t_pulses;
    int done_at;
    t_pulses = 0;
    done_at  = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput({v.name, ".launch_cycle"}, cycle_count, 0);
    checkOutput({v.name, ".launch_stray"}, stray_wr, 0);
    checkOutput({v.name, ".launch_busy"}, busy, 1);
    for (int k = 0; k < 300; k++) begin
      if (k >= v.wr_delay && k < v.wr_delay + v.wr_num) begin
        kernel_wr_en   = 1'b1;
        kernel_wr_addr = (v.addr_mode == 1) ? ADDR_WIDTH'(ord_addr[k - v.wr_delay])
                                            : ADDR_WIDTH'(k - v.wr_delay);
      end else begin
        kernel_wr_en   = 1'b0;
        kernel_wr_addr = '0;
      end
      if (t) t_pulses++;
      if (done) begin
        done_at = k;
        checkOutput({v.name, ".done_busy"}, busy, 0);
        checkOutput({v.name, ".done_cycle"}, cycle_count, v.exp_cycle);
      end
      tick();
      if (done_at >= 0) break;
    end
    kernel_wr_en = 1'b0;
    checkOutput({v.name, ".done_at"}, done_at, v.exp_done_at);
    checkOutput({v.name, ".t_pulses"}, t_pulses, 1);
    checkOutput({v.name, ".idle_done"}, done, 0);
    checkOutput({v.name, ".idle_busy"}, busy, 0);
    checkOutput({v.name, ".cycle_count"}, cycle_count, v.exp_cycle);
    checkOutput({v.name, ".wr_count"}, wr_count, v.exp_wr_count);
    checkOutput({v.name, ".first_wr_lat"}, first_wr_lat, v.exp_first_lat);
    checkOutput({v.name, ".timeout"}, timeout, v.exp_timeout);
    checkOutput({v.name, ".stray_wr"}, stray_wr, v.exp_stray);
    checkOutput({v.name, ".order_err"}, order_err, v.exp_order_err);
    checkOutput({v.name, ".order_err_addr"}, order_err_addr, v.exp_order_addr);
    tick();
    checkOutput({v.name, ".cycle_hold"}, cycle_count, v.exp_cycle);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t_pulses;
    int done_pulses;

    vecs[0] = '{"nominal",     20, 16, 0,  36,  35, 16, 20, 0, 0, 0, 0};
    vecs[1] = '{"timeout",     20,  5, 0, 101, 100,  5, 20, 1, 0, 0, 0};
    vecs[2] = '{"simult",      85, 16, 0, 101, 100, 16, 85, 0, 0, 0, 0};
    vecs[3] = '{"launch_wr",    0, 16, 0,  16,  15, 16,  0, 0, 0, 0, 0};
    vecs[4] = '{"no_writes",    0,  0, 0, 101, 100,  0,  0, 1, 0, 0, 0};
    vecs[5] = '{"over_write",  10, 20, 0,  26,  25, 16, 10, 0, 1, 0, 0};
    vecs[6] = '{"order",       20,  6, 1, 101, 100,  6, 20, 1, 0, ORD_ERR, ORD_ADDR};

    rst            = 1'b0;
    start          = 1'b0;
    kernel_wr_en   = 1'b0;
    kernel_wr_addr = '0;
    #12;
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.t", t, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.wr_count", wr_count, 0);
    checkOutput("reset.cycle_count", cycle_count, 0);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("post_reset.busy", busy, 0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Stray write in IDLE, then start held high during RUN must not relaunch.
    kernel_wr_en = 1'b1;
    tick();
    kernel_wr_en = 1'b0;
    checkOutput("stray.set", stray_wr, 1);
    tick();
    checkOutput("stray.sticky", stray_wr, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("stray.cleared_at_launch", stray_wr, 0);
    t_pulses    = 0;
    done_pulses = 0;
    for (int k = 0; k < 60; k++) begin
      start          = (k >= 5 && k < 30);
      kernel_wr_en   = (k >= 20 && k < 36);
      kernel_wr_addr = ADDR_WIDTH'(k - 20);
      if (t) t_pulses++;
      if (done) done_pulses++;
      tick();
    end
    start        = 1'b0;
    kernel_wr_en = 1'b0;
    checkOutput("busy_start.t_pulses", t_pulses, 1);
    checkOutput("busy_start.done_pulses", done_pulses, 1);
    checkOutput("busy_start.wr_count", wr_count, 16);
    checkOutput("busy_start.busy", busy, 0);

    // Reset asserted during the t pulse.
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("rst_launch.t_before", t, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_launch.t", t, 0);
    checkOutput("rst_launch.busy", busy, 0);
    checkOutput("rst_launch.stray_wr", stray_wr, 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checkOutput("rst_launch.idle_busy", busy, 0);
    checkOutput("rst_launch.idle_t", t, 0);

    // Reset asserted mid-RUN with writes in flight.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      kernel_wr_en   = (k >= 20);
      kernel_wr_addr = ADDR_WIDTH'(k - 20);
      tick();
    end
    checkOutput("rst_run.wr_count_before", wr_count, 10);
    checkOutput("rst_run.cycle_before", cycle_count, 30);
    #2;
    rst = 1'b0;
    kernel_wr_en = 1'b0;
    #1;
    checkOutput("rst_run.busy", busy, 0);
    checkOutput("rst_run.wr_count", wr_count, 0);
    checkOutput("rst_run.cycle_count", cycle_count, 0);
    checkOutput("rst_run.first_wr_lat", first_wr_lat, 0);
    checkOutput("rst_run.done", done, 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checkOutput("rst_run.idle_busy", busy, 0);
    applyStimulus(vecs[0]);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
